// File: rtl/stall_flush_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stall_flush_ctrl
// Description : Stall/flush controller for the 5-stage RV32I pipeline. It
//               covers load-use hazards, taken branches/jumps resolved in E,
//               and multi-cycle data-memory accesses, with a timeout.
//               Optional macro HAZ_PERF_EN adds stall/flush cycle counters.
// Revision    : 1.0 - initial release
// ============================================================================
module stall_flush_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] InstrD,
    input  logic [31:0] InstrE,
    input  logic        PCSrcE,
    input  logic        DmemReqM,
    input  logic        DmemReadyM,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic        MemErr,
    output logic [31:0] StallCnt,
    output logic [31:0] FlushCnt
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;

    logic [4:0] rdE, rs1D, rs2D;
    logic [6:0] opD;
    logic       loadE, usesRs1D, usesRs2D, lwStall;
    logic       memWait, timeout, memWaitEff;
    logic       stall_f, stall_d, stall_e, stall_m;
    logic       flush_d, flush_e, flush_w, mem_err;
    logic       unused_bits;

    assign rdE  = InstrE[11:7];
    assign rs1D = InstrD[19:15];
    assign rs2D = InstrD[24:20];
    assign opD  = InstrD[6:0];

    assign loadE    = (InstrE[6:0] == OP_LOAD);
    assign usesRs1D = !((opD == OP_LUI) || (opD == OP_AUIPC) || (opD == OP_JAL));
    assign usesRs2D = (opD == OP_R) || (opD == OP_S) || (opD == OP_B);

    assign lwStall = loadE && (rdE != 5'd0) &&
                     ((usesRs1D && (rs1D == rdE)) || (usesRs2D && (rs2D == rdE)));

    assign memWait = DmemReqM && !DmemReadyM;

    // On the last allowed wait cycle the access is abandoned: stalls drop
    // in the same cycle that MemErr fires.
    assign timeout    = (state_q == ST_MEM_WAIT) && (cnt_q == TO_LAST);
    assign memWaitEff = memWait && !timeout;

    assign unused_bits = ^{InstrD[31:25], InstrD[14:7], InstrE[31:12]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        mem_err = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (memWait) begin
                    state_d = ST_MEM_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_MEM_WAIT: begin
                if (!memWait || timeout) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            default: state_d = ST_RUN;
        endcase

        mem_err = timeout && memWait;

        if (memWaitEff) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (PCSrcE) begin
            // Wrong-path instruction in D is discarded, so no load-use stall.
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (lwStall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    assign StallF = rst_n && stall_f;
    assign StallD = rst_n && stall_d;
    assign StallE = rst_n && stall_e;
    assign StallM = rst_n && stall_m;
    assign FlushD = rst_n && flush_d;
    assign FlushE = rst_n && flush_e;
    assign FlushW = rst_n && flush_w;
    assign MemErr = rst_n && mem_err;

`ifdef HAZ_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (StallF) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (FlushD || FlushE || FlushW) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
`else
    assign StallCnt = 32'd0;
    assign FlushCnt = 32'd0;
`endif

endmodule
`default_nettype wire
